// File: rtl/term_pkg.sv
// Shared types and constants for the character terminal controller.
// Holds the FSM state enum, control bytes, blank cell value and VRAM widths.
package term_pkg;

    localparam int ADDR_W = 11;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int DATA_W = 9;

    localparam logic [DATA_W-1:0] BLANK = 9'h020;

    localparam logic [7:0] CH_BEL = 8'h07;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_SO  = 8'h0E;
    localparam logic [7:0] CH_SI  = 8'h0F;
    localparam logic [7:0] PR_LO  = 8'h20;
    localparam logic [7:0] PR_HI  = 8'h7E;

`ifdef TERM_SCROLL_EN
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_SCRL_RD,
        ST_SCRL_WR,
        ST_CLR_ROW
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_CLR_ROW
    } state_t;
`endif

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PR_LO) && (b <= PR_HI);
    endfunction

endpackage

// File: rtl/bel_pulse.sv
// Visual bell timer: holds o_pulse high for BEL_TICKS clocks after i_trig.
// Ports: i_clk, i_rst_n, i_trig (restart), o_pulse (bell active).
module bel_pulse #(
    parameter int BEL_TICKS = 1200000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trig,
    output logic o_pulse
);

    localparam int CW = $clog2(BEL_TICKS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (i_trig)
            cnt <= CW'(BEL_TICKS);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign o_pulse = (cnt != '0);

endmodule

// File: rtl/term_ctrl.sv
// Character terminal controller: consumes a byte stream and maintains a
// VRAM text screen (cursor, reverse video, CR/LF/BS/FF, scroll, visual bell).
// Ports: i_clk, i_rst_n, i_rx_data/i_rx_valid/o_rx_ready byte input,
// o_vram_addr/o_vram_din/i_vram_dout/o_vram_ce/o_vram_wre VRAM port A,
// o_reversev visual bell.
// Build option: TERM_SCROLL_EN makes a last-row line feed scroll the
// screen up; without it the cursor wraps to row 0 and that row is blanked.
module term_ctrl #(
    parameter int COLS      = 60,
    parameter int ROWS      = 17,
    parameter int BEL_TICKS = 1200000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [10:0] o_vram_addr,
    output logic [8:0]  o_vram_din,
    input  logic [8:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic        o_reversev
);

    import term_pkg::*;

    localparam logic [X_W-1:0] LAST_X = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(ROWS - 1);

    state_t              state, state_n;
    logic [X_W-1:0]      cur_x, cur_x_n;
    logic [Y_W-1:0]      cur_y, cur_y_n;
    logic                rev, rev_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic [7:0]          chr, chr_n;
    logic                lf;
    logic                bel_trig;
    logic                rx_ready;
    logic                ce;
    logic                wre;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
    logic [X_W-1:0]      ptr_x;
    logic [Y_W-1:0]      ptr_y;
    logic                bel_on;

    // ptr doubles as a flat 0..2047 clear counter and a {row, col} walker
    assign ptr_x = ptr[X_W-1:0];
    assign ptr_y = ptr[ADDR_W-1:X_W];

`ifndef TERM_SCROLL_EN
    logic unused_dout;
    assign unused_dout = ^i_vram_dout;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_CLEAR;
        else
            state <= state_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
            rev   <= 1'b0;
            ptr   <= '0;
            chr   <= '0;
        end else begin
            cur_x <= cur_x_n;
            cur_y <= cur_y_n;
            rev   <= rev_n;
            ptr   <= ptr_n;
            chr   <= chr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cur_x_n  = cur_x;
        cur_y_n  = cur_y;
        rev_n    = rev;
        ptr_n    = ptr;
        chr_n    = chr;
        lf       = 1'b0;
        bel_trig = 1'b0;
        rx_ready = 1'b0;
        ce       = 1'b0;
        wre      = 1'b0;
        addr     = '0;
        din      = '0;

        unique case (state)
            ST_CLEAR: begin
                ce    = 1'b1;
                wre   = 1'b1;
                addr  = ptr;
                din   = BLANK;
                ptr_n = ptr + ADDR_W'(1);
                if (ptr == '1) begin
                    cur_x_n = '0;
                    cur_y_n = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rx_ready = 1'b1;
                addr     = {cur_y, cur_x};
                if (i_rx_valid) begin
                    unique case (1'b1)
                        is_printable(i_rx_data): begin
                            chr_n   = i_rx_data;
                            state_n = ST_PUT;
                        end
                        (i_rx_data == CH_CR): cur_x_n = '0;
                        (i_rx_data == CH_LF): lf = 1'b1;
                        (i_rx_data == CH_BS): begin
                            if (cur_x != '0)
                                cur_x_n = cur_x - X_W'(1);
                        end
                        (i_rx_data == CH_FF): begin
                            cur_x_n = '0;
                            cur_y_n = '0;
                            ptr_n   = '0;
                            state_n = ST_CLEAR;
                        end
                        (i_rx_data == CH_SO):  rev_n    = 1'b1;
                        (i_rx_data == CH_SI):  rev_n    = 1'b0;
                        (i_rx_data == CH_BEL): bel_trig = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_PUT: begin
                ce      = 1'b1;
                wre     = 1'b1;
                addr    = {cur_y, cur_x};
                din     = {rev, chr};
                state_n = ST_IDLE;
                if (cur_x == LAST_X) begin
                    cur_x_n = '0;
                    lf      = 1'b1;
                end else begin
                    cur_x_n = cur_x + X_W'(1);
                end
            end
`ifdef TERM_SCROLL_EN
            ST_SCRL_RD: begin
                ce      = 1'b1;
                addr    = ptr;
                state_n = ST_SCRL_WR;
            end
            ST_SCRL_WR: begin
                // read data for ptr arrives now; copy it one row up
                ce      = 1'b1;
                wre     = 1'b1;
                addr    = {ptr_y - Y_W'(1), ptr_x};
                din     = i_vram_dout;
                state_n = ST_SCRL_RD;
                if (ptr_x == LAST_X) begin
                    if (ptr_y == LAST_Y) begin
                        ptr_n   = {LAST_Y, X_W'(0)};
                        state_n = ST_CLR_ROW;
                    end else begin
                        ptr_n = {ptr_y + Y_W'(1), X_W'(0)};
                    end
                end else begin
                    ptr_n = ptr + ADDR_W'(1);
                end
            end
`endif
            ST_CLR_ROW: begin
                ce   = 1'b1;
                wre  = 1'b1;
                addr = ptr;
                din  = BLANK;
                if (ptr_x == LAST_X)
                    state_n = ST_IDLE;
                else
                    ptr_n = ptr + ADDR_W'(1);
            end
            default: state_n = ST_CLEAR;
        endcase

        // line feed shared by LF and end-of-line wrap after PUT
        if (lf) begin
            if (cur_y != LAST_Y) begin
                cur_y_n = cur_y + Y_W'(1);
            end else begin
`ifdef TERM_SCROLL_EN
                ptr_n   = {Y_W'(1), X_W'(0)};
                state_n = ST_SCRL_RD;
`else
                cur_y_n = '0;
                ptr_n   = '0;
                state_n = ST_CLR_ROW;
`endif
            end
        end
    end

    bel_pulse #(
        .BEL_TICKS (BEL_TICKS)
    ) u_bel (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_trig  (bel_trig),
        .o_pulse (bel_on)
    );

    // state resets to CLEAR, so outputs are forced low while reset is held
    assign o_rx_ready  = rx_ready & i_rst_n;
    assign o_vram_ce   = ce & i_rst_n;
    assign o_vram_wre  = wre & i_rst_n;
    assign o_vram_addr = i_rst_n ? addr : '0;
    assign o_vram_din  = i_rst_n ? din : '0;
    assign o_reversev  = bel_on;

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl with a screen-level reference model.
// Drives random and directed byte streams and checks VRAM and cursor.
module tb_term_ctrl;

    localparam int COLS = 60;
    localparam int ROWS = 17;
    localparam int BT   = 10;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [10:0] o_vram_addr;
    logic [8:0]  o_vram_din;
    logic [8:0]  i_vram_dout = 9'h000;
    logic        o_vram_ce;
    logic        o_vram_wre;
    logic        o_reversev;

    int checks = 0;
    int fails  = 0;
    int bel_hi = 0;

    logic [8:0]  mem [0:2047];
    logic [19:0] wq [$];

    logic [8:0]  exp_mem [0:2047];
    int          cx, cy;
    bit          rev_m;

    always #5 i_clk = ~i_clk;

    term_ctrl #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BEL_TICKS (BT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_vram_addr (o_vram_addr),
        .o_vram_din  (o_vram_din),
        .i_vram_dout (i_vram_dout),
        .o_vram_ce   (o_vram_ce),
        .o_vram_wre  (o_vram_wre),
        .o_reversev  (o_reversev)
    );

    always @(posedge i_clk) begin
        if (o_vram_ce && o_vram_wre) begin
            mem[o_vram_addr] <= o_vram_din;
            wq.push_back({o_vram_addr, o_vram_din});
        end
        if (o_vram_ce && !o_vram_wre)
            i_vram_dout <= mem[o_vram_addr];
    end

    always @(negedge i_clk)
        if (o_reversev) bel_hi++;

    function automatic void model_clear();
        for (int i = 0; i < 2048; i++) exp_mem[i] = 9'h020;
        cx = 0;
        cy = 0;
    endfunction

    function automatic void model_lf();
        if (cy < ROWS - 1) begin
            cy++;
        end else begin
`ifdef TERM_SCROLL_EN
            for (int r = 1; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    exp_mem[(r-1)*64 + c] = exp_mem[r*64 + c];
            for (int c = 0; c < COLS; c++)
                exp_mem[(ROWS-1)*64 + c] = 9'h020;
`else
            cy = 0;
            for (int c = 0; c < COLS; c++) exp_mem[c] = 9'h020;
`endif
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_mem[cy*64 + cx] = {rev_m, b};
            cx++;
            if (cx == COLS) begin
                cx = 0;
                model_lf();
            end
        end else begin
            case (b)
                8'h0D: cx = 0;
                8'h0A: model_lf();
                8'h08: if (cx > 0) cx--;
                8'h0C: model_clear();
                8'h0E: rev_m = 1'b1;
                8'h0F: rev_m = 1'b0;
                default: ;
            endcase
        end
    endfunction

    function automatic logic [10:0] exp_addr();
        return 11'(cy*64 + cx);
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!o_rx_ready && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rx_ready) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout: ready=%0b after %0d clocks, required 1",
                     o_rx_ready, n);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        wait_ready(n);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
        model_apply(b);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h41;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %0b, required 0", o_rx_ready);
        end
        checks++;
        if ({o_vram_ce, o_vram_wre} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ce_wre: got %b, required 00", {o_vram_ce, o_vram_wre});
        end
        checks++;
        if (o_vram_addr !== 11'h000) begin
            fails++;
            $display("FAIL reset_addr: got %h, required 000", o_vram_addr);
        end
        checks++;
        if (o_vram_din !== 9'h000) begin
            fails++;
            $display("FAIL reset_din: got %h, required 000", o_vram_din);
        end
        checks++;
        if (o_reversev !== 1'b0) begin
            fails++;
            $display("FAIL reset_reversev: got %0b, required 0", o_reversev);
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_clear_after_reset(input string tag);
        int n;
        int bad;
        wq.delete();
        model_clear();
        rev_m   = 1'b0;
        i_rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 2048) begin
            fails++;
            $display("FAIL %s_clear_cycles: got %0d, required 2048", tag, n);
        end
        checks++;
        if (wq.size() != 2048) begin
            fails++;
            $display("FAIL %s_clear_writes: got %0d, required 2048", tag, wq.size());
        end
        bad = 0;
        foreach (wq[i])
            if (wq[i] !== {11'(i), 9'h020}) bad++;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_clear_order: %0d bad writes, required 0", tag, bad);
        end
        checks++;
        if (o_vram_addr !== 11'h000 || o_vram_ce !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_cursor: addr=%h ce=%0b, required 000 0",
                     tag, o_vram_addr, o_vram_ce);
        end
    endtask

    task automatic test_put_a();
        wq.delete();
        send(8'h41);
        checks++;
        if (o_rx_ready !== 1'b0 || o_vram_wre !== 1'b1 || o_vram_din !== 9'h041) begin
            fails++;
            $display("FAIL put_cycle: ready=%0b wre=%0b din=%h, required 0 1 041",
                     o_rx_ready, o_vram_wre, o_vram_din);
        end
        @(negedge i_clk);
        checks++;
        if (o_rx_ready !== 1'b1 || o_vram_addr !== 11'h001) begin
            fails++;
            $display("FAIL put_ready: ready=%0b addr=%h, required 1 001",
                     o_rx_ready, o_vram_addr);
        end
        checks++;
        if (wq.size() != 1 || wq[0] !== {11'h000, 9'h041}) begin
            fails++;
            $display("FAIL put_write: count=%0d first=%h, required 1 %h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 20'h0, {11'h000, 9'h041});
        end
    endtask

    task automatic test_rev();
        int n;
        send(8'h0D);
        wq.delete();
        send(8'h0E);
        send(8'h42);
        send(8'h0F);
        send(8'h43);
        wait_ready(n);
        checks++;
        if (mem[0] !== 9'h142 || mem[1] !== 9'h043) begin
            fails++;
            $display("FAIL rev_cells: got %h %h, required 142 043", mem[0], mem[1]);
        end
        checks++;
        if (wq.size() != 2 || o_vram_addr !== 11'h002) begin
            fails++;
            $display("FAIL rev_writes: count=%0d addr=%h, required 2 002",
                     wq.size(), o_vram_addr);
        end
    endtask

    task automatic test_wrap_bs();
        int n;
        int bad;
        send(8'h0D);
        for (int i = 0; i < COLS; i++)
            send(8'($urandom_range(32, 126)));
        wait_ready(n);
        checks++;
        if (o_vram_addr !== 11'h040) begin
            fails++;
            $display("FAIL wrap_cursor: got %h, required 040", o_vram_addr);
        end
        bad = 0;
        for (int c = 0; c < COLS; c++)
            if (mem[c] !== exp_mem[c]) bad++;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wrap_row0: %0d cells differ, required 0", bad);
        end
        send(8'h08);
        wait_ready(n);
        checks++;
        if (o_vram_addr !== 11'h040) begin
            fails++;
            $display("FAIL bs_at_zero: got %h, required 040", o_vram_addr);
        end
        send(8'h78);
        send(8'h78);
        send(8'h08);
        wait_ready(n);
        checks++;
        if (o_vram_addr !== 11'h041) begin
            fails++;
            $display("FAIL bs_dec: got %h, required 041", o_vram_addr);
        end
    endtask

    task automatic test_scroll();
        int n;
        int bad;
        while (cy != ROWS - 1) send(8'h0A);
        send(8'h0D);
        send(8'h5A);
        send(8'h0A);
        wait_ready(n);
`ifdef TERM_SCROLL_EN
        checks++;
        if (n != 2*16*60 + 60) begin
            fails++;
            $display("FAIL scroll_busy: got %0d, required %0d", n, 2*16*60 + 60);
        end
        checks++;
        if (mem[15*64] !== 9'h05A) begin
            fails++;
            $display("FAIL scroll_moved: got %h, required 05A", mem[15*64]);
        end
        bad = 0;
        for (int c = 0; c < COLS; c++)
            if (mem[16*64 + c] !== 9'h020) bad++;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL scroll_lastrow: %0d non-blank, required 0", bad);
        end
        checks++;
        if (o_vram_addr !== {5'd16, 6'd1}) begin
            fails++;
            $display("FAIL scroll_cursor: got %h, required %h", o_vram_addr, {5'd16, 6'd1});
        end
`else
        checks++;
        if (n != 60) begin
            fails++;
            $display("FAIL wrap_busy: got %0d, required 60", n);
        end
        checks++;
        if (mem[16*64] !== 9'h05A) begin
            fails++;
            $display("FAIL wrap_kept: got %h, required 05A", mem[16*64]);
        end
        bad = 0;
        for (int c = 0; c < COLS; c++)
            if (mem[c] !== 9'h020) bad++;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wrap_row0_blank: %0d non-blank, required 0", bad);
        end
        checks++;
        if (o_vram_addr !== {5'd0, 6'd1}) begin
            fails++;
            $display("FAIL wrap_cursor_top: got %h, required %h", o_vram_addr, {5'd0, 6'd1});
        end
`endif
    endtask

    task automatic test_bel();
        int n;
        bel_hi = 0;
        send(8'h07);
        repeat (30) @(negedge i_clk);
        checks++;
        if (bel_hi != BT) begin
            fails++;
            $display("FAIL bel_len: got %0d, required %0d", bel_hi, BT);
        end
        bel_hi = 0;
        send(8'h07);
        repeat (4) @(negedge i_clk);
        send(8'h07);
        send(8'h51);
        wait_ready(n);
        checks++;
        if (o_reversev !== 1'b1 || o_vram_addr !== exp_addr()) begin
            fails++;
            $display("FAIL bel_concurrent: rv=%0b addr=%h, required 1 %h",
                     o_reversev, o_vram_addr, exp_addr());
        end
        repeat (30) @(negedge i_clk);
        checks++;
        if (bel_hi != BT + 5) begin
            fails++;
            $display("FAIL bel_restart: got %0d, required %0d", bel_hi, BT + 5);
        end
    endtask

    task automatic test_random();
        int n;
        int r;
        int bad;
        logic [7:0] b;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0A;
            else if (r < 78) b = 8'h0D;
            else if (r < 84) b = 8'h08;
            else if (r < 88) b = 8'h0E;
            else if (r < 92) b = 8'h0F;
            else if (r < 94) b = 8'h0C;
            else if (r < 96) b = 8'h07;
            else if (r < 98) b = 8'($urandom_range(0, 6));
            else             b = 8'($urandom_range(127, 255));
            send(b);
            wait_ready(n);
            checks++;
            if (o_vram_addr !== exp_addr()) begin
                fails++;
                $display("FAIL rand_cursor[%0d] byte %h: got %h, required %h",
                         i, b, o_vram_addr, exp_addr());
            end
        end
        bad = 0;
        r = -1;
        for (int a = 0; a < 2048; a++)
            if (mem[a] !== exp_mem[a]) begin
                bad++;
                if (r < 0) r = a;
            end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rand_screen: %0d cells differ, first at %h got %h required %h",
                     bad, r, mem[r], exp_mem[r]);
        end
    endtask

    task automatic test_reset_mid();
        while (cy != ROWS - 1) send(8'h0A);
        send(8'h07);
        send(8'h0A);
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rx_ready, o_vram_ce, o_vram_wre, o_reversev} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_ctrl: got %b, required 0000",
                     {o_rx_ready, o_vram_ce, o_vram_wre, o_reversev});
        end
        checks++;
        if ({o_vram_addr, o_vram_din} !== 20'h0) begin
            fails++;
            $display("FAIL midrst_bus: addr=%h din=%h, required 000 000",
                     o_vram_addr, o_vram_din);
        end
        repeat (2) @(negedge i_clk);
        test_clear_after_reset("midrst");
    endtask

    initial begin
        cx    = 0;
        cy    = 0;
        rev_m = 1'b0;
        test_reset();
        test_clear_after_reset("por");
        test_put_a();
        test_rev();
        test_wrap_bs();
        test_scroll();
        test_bel();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 60, visible columns (1..64).
REQ-002 SHALL have parameter ROWS, default 17, visible rows (2..32).
REQ-003 SHALL have parameter BEL_TICKS, default 1200000, reverse-video duration in clocks for BEL.
REQ-004 SHALL have port i_clk, input, 1, the single system clock (12 MHz).
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_rx_data, input, 8, received character.
REQ-007 SHALL have port i_rx_valid, input, 1, i_rx_data valid.
REQ-008 SHALL have port o_rx_ready, output, 1, character accepted when valid and ready are both high on a rising edge.
REQ-009 SHALL have port o_vram_addr, output, 11, VRAM port A address {y[4:0], x[5:0]}.
REQ-010 SHALL have port o_vram_din, output, 9, write data {reverse, char[7:0]}.
REQ-011 SHALL have port i_vram_dout, input, 9, read data, valid one clock after a read with ce=1 and wre=0.
REQ-012 SHALL have ports o_vram_ce and o_vram_wre, outputs, 1 each, clock enable and write enable (1 = write).
REQ-013 SHALL have port o_reversev, output, 1, visual-bel request.

Function
REQ-014 States SHALL be CLEAR, IDLE, PUT, SCRL_RD, SCRL_WR, CLR_ROW.
REQ-015 In IDLE, o_rx_ready SHALL be 1 and o_vram_addr SHALL equal {cur_y, cur_x}, so the cursor is displayed there; o_rx_ready SHALL be 0 in all other states.
REQ-016 An accepted byte in 0x20..0x7E SHALL be handled in PUT: one write of {rev, byte} at the cursor in the next cycle, then cur_x+1, then return to IDLE (2 cycles, accept to ready).
REQ-017 If cur_x reaches COLS after a PUT, the controller SHALL set cur_x=0 and perform a line feed.
REQ-018 Control bytes: 0x0D SHALL set cur_x=0; 0x0A SHALL line-feed; 0x08 SHALL decrement cur_x if nonzero, else no change; 0x0C SHALL enter CLEAR and home the cursor; 0x0E SHALL set rev=1; 0x0F SHALL clear rev=0; 0x07 SHALL start the bel; all other bytes SHALL be ignored. Each control byte SHALL return to IDLE in 1 cycle except 0x0C and a scrolling line feed.
REQ-019 Line feed with cur_y<ROWS-1 SHALL increment cur_y; with cur_y=ROWS-1 it SHALL scroll.
REQ-020 Scroll: for rows 1..ROWS-1 and columns 0..COLS-1, the controller SHALL read the cell in SCRL_RD and write i_vram_dout to row-1 in SCRL_WR; it SHALL then write 9'h020 to all COLS cells of row ROWS-1 in CLR_ROW; cur_y SHALL remain ROWS-1.
REQ-021 CLEAR SHALL write 9'h020 to all 2048 addresses in ascending order, one per clock, then set cur_x=cur_y=0, then go to IDLE.
REQ-022 o_vram_ce SHALL be high only in clocks that issue an access; o_vram_wre SHALL be high only in write clocks.
REQ-023 BEL SHALL drive o_reversev=1 for BEL_TICKS clocks; a BEL arriving during an active bel SHALL restart the count; the bel SHALL run concurrently with character processing.
REQ-024 rev SHALL persist across lines, scrolls and clears until the next 0x0F or a reset.

Reset
REQ-025 While i_rst_n=0, all outputs SHALL be 0; cur_x, cur_y, rev and the bel counter SHALL be 0; the state SHALL be CLEAR.
REQ-026 After reset release, the controller SHALL run a full CLEAR before the first o_rx_ready.
REQ-027 Reset asserted mid-scroll or mid-clear SHALL abort immediately, and the operation SHALL restart as a full CLEAR.

Configuration
REQ-028 With TERM_SCROLL_EN defined, line feed on the last row SHALL scroll as in REQ-020.
REQ-029 Without TERM_SCROLL_EN, line feed on the last row SHALL set cur_y=0 and clear row 0 via CLR_ROW; the SCRL states SHALL be absent.

Structure
REQ-030 Package term_pkg SHALL hold the state enum, the control-byte constants, BLANK=9'h020, and the VRAM address width constants.
REQ-031 The bel counter SHALL be the sub-module bel_pulse (i_clk, i_rst_n, i_trig, o_pulse, parameter BEL_TICKS).

Verification
REQ-032 Reset, then send 'A' (0x41) -> 2048 blank writes, then a write of 9'h041 at address 0; cursor address becomes 11'h001.
REQ-033 Send 0x0E, 'B', 0x0F, 'C' -> writes 9'h142 at x=0 and 9'h043 at x=1.
REQ-034 With COLS=60, send 60 printable bytes on row 0 -> cursor moves to {y=1, x=0}; 0x08 at x=0 leaves the cursor unchanged.
REQ-035 With TERM_SCROLL_EN, put the cursor on row 16, write 'Z' on row 16, then send LF -> 'Z' appears on row 15, row 16 is blank, and ready is low for 2*16*60+60 clocks.
REQ-036 With BEL_TICKS=10, send 0x07 -> o_reversev is high for exactly 10 clocks; a second 0x07 at tick 5 extends it to 15 clocks total.
REQ-037 Assert i_rst_n=0 mid-scroll -> all outputs 0 immediately; after release, a full CLEAR completes and ready returns.
